grid_memory_banked: RTL and testbench
=====================================

// Module: grid_memory_banked
// PURPOSE
//  Multi-row, double-buffered Game-of-Life state store; parametrised successor to the single-row memory.
//  Holds ROWS rows of WIDTH cells in two flop banks: active (read by calculator) and shadow (written by calculator).
//  Load mode: host fills active bank row-by-row. Run mode: calculator reads toroidal 3-row neighbourhoods, writes next gen to shadow, then swaps.
//  Tracks frame completeness and generation count.
// PARAMETERS
//  WIDTH  64  cells per row (row word width)
//  ROWS   64  rows per bank; >=3
//  ADDR_W $clog2(ROWS)  row address width (derived, do not override)
//  GEN_W  16  generation counter width
// PORTS
//  clk            in   1       system clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  load_run       in   1       0 = load mode, 1 = run mode
//  load_we        in   1       host row write strobe (load mode only)
//  load_addr      in   ADDR_W  host row address
//  initial_in     in   WIDTH   host row data
//  grid_we        in   1       calculator row write strobe (run mode only)
//  grid_addr      in   ADDR_W  calculator row address
//  grid_in        in   WIDTH   calculator next-gen row data
//  swap           in   1       request bank swap (1-cycle pulse)
//  rd_en          in   1       neighbourhood read request
//  rd_addr        in   ADDR_W  centre row of read
//  row_prev       out  WIDTH   active[(rd_addr-1) mod ROWS]
//  row_cur        out  WIDTH   active[rd_addr]
//  row_next       out  WIDTH   active[(rd_addr+1) mod ROWS]
//  rd_valid       out  1       row_* valid this cycle
//  frame_complete out  1       every shadow row written since last swap/mode change
//  swap_err       out  1       1-cycle pulse: swap rejected
//  gen_count      out  GEN_W   completed generations in current run
// BEHAVIOUR
//  Reset (reset=0, async): both banks, bank_sel, written mask, gen_count, row_*, rd_valid, swap_err -> 0. Reset mid-operation discards everything.
//  active = bank[bank_sel], shadow = bank[!bank_sel]; bank_sel toggles only on accepted swap.
//  Load mode: load_we writes initial_in to active[load_addr] at edge. grid_we, swap ignored (no swap_err).
//    Written mask and gen_count held at 0.
//  Run mode: grid_we writes grid_in to shadow[grid_addr], sets mask bit. load_we ignored. Rewriting a row is legal (last wins).
//  Any addr >= ROWS on a write: write dropped, mask unchanged.
//  frame_complete = &mask (combinational from registered mask).
//  Swap accepted iff run mode & frame_complete & !grid_we: bank_sel toggles, mask cleared, gen_count+1 (wraps 2^GEN_W-1 -> 0).
//  Swap otherwise in run mode: no state change, swap_err=1 next cycle for 1 cycle.
//  swap & grid_we same cycle: write performed, swap rejected (swap_err).
//  Any load_run transition: mask cleared; gen_count cleared on entry to load mode.
//  Read latency 1: rd_en sampled at edge N -> row_*/rd_valid at N+1, from active bank as of edge N (pre-swap if swap at N).
//  Wrap: rd_addr=0 -> row_prev=row ROWS-1; rd_addr=ROWS-1 -> row_next=row 0.
//  rd_addr >= ROWS: rd_valid=1, row_* = 0. rd_en=0: rd_valid=0, row_* hold.
//  Reads legal in both modes (load-mode readback). Back-to-back reads: one result per cycle.
//  Write and read of same active row in load mode same edge: read returns old data.
// TESTING
//  Reset then rd_en addr 5 -> rd_valid=1 next cycle, all rows 0; gen_count=0.
//  Load mode (WIDTH=8,ROWS=4): rows 0..3 = 01,02,04,08; read addr 0 -> prev=08 cur=01 next=02; addr 3 -> 04,08,01.
//  Run: write shadow rows 0..2 only, swap -> swap_err pulse, gen_count 0; write row 3, swap -> gen_count 1, reads return new data.
//  grid_we row 3 with swap in same cycle when rows 0..2 written -> swap_err, row 3 written, next-cycle swap accepted.
//  gen_count at 2^GEN_W-1 plus accepted swap -> 0; load_run 1->0 clears gen_count and frame_complete.
//  Assert reset mid-frame with rd_en active -> all outputs 0 asynchronously, memory reads 0 after release.

Source files
------------

// File: rtl/grid_memory_banked.sv
// Double-buffered Game-of-Life row store: host loads the active bank, the calculator fills the shadow bank, swap flips them.
// Reads: 1-cycle latency toroidal 3-row window; swap accepted only once every shadow row is written.
module grid_memory_banked #(
   parameter int WIDTH  = 64,
   parameter int ROWS   = 64,
   parameter int ADDR_W = $clog2(ROWS),
   parameter int GEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_run,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [WIDTH-1:0]  initial_in,
   input  logic              grid_we,
   input  logic [ADDR_W-1:0] grid_addr,
   input  logic [WIDTH-1:0]  grid_in,
   input  logic              swap,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  row_prev,
   output logic [WIDTH-1:0]  row_cur,
   output logic [WIDTH-1:0]  row_next,
   output logic              rd_valid,
   output logic              frame_complete,
   output logic              swap_err,
   output logic [GEN_W-1:0]  gen_count
);

   localparam logic [ADDR_W:0]   NROWS = (ADDR_W+1)'(ROWS);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(ROWS - 1);

   logic [WIDTH-1:0]  r_bank [2][ROWS];
   logic              r_bank_sel;
   logic [ROWS-1:0]   r_mask;
   logic [GEN_W-1:0]  r_gen;
   logic [WIDTH-1:0]  r_prev, r_cur, r_next;
   logic              r_rd_valid;
   logic              r_swap_err;

   logic              w_shd_sel;
   logic              w_load_wr;
   logic              w_grid_wr;
   logic              w_swap_ok;
   logic              w_swap_rej;
   logic              w_rd_ok;
   logic [ADDR_W-1:0] w_prev_idx;
   logic [ADDR_W-1:0] w_next_idx;

   assign w_shd_sel  = ~r_bank_sel;
   assign w_load_wr  = ~load_run & load_we & ({1'b0, load_addr} < NROWS);
   assign w_grid_wr  =  load_run & grid_we & ({1'b0, grid_addr} < NROWS);
   assign w_rd_ok    = ({1'b0, rd_addr} < NROWS);

   // A write in the same cycle blocks the swap so the frame it belongs to is never lost.
   assign w_swap_ok  = load_run & swap & (&r_mask) & ~grid_we;
   assign w_swap_rej = load_run & swap & ~w_swap_ok;

   assign w_prev_idx = (rd_addr == '0)   ? LAST : rd_addr - 1'b1;
   assign w_next_idx = (rd_addr == LAST) ? '0   : rd_addr + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROWS; r++) begin
               r_bank[b][r] <= '0;
            end
         end
      end else begin
         if (w_load_wr) r_bank[r_bank_sel][load_addr] <= initial_in;
         if (w_grid_wr) r_bank[w_shd_sel][grid_addr] <= grid_in;
      end
   end

   // Load mode pins mask and generation at zero, which also covers clearing on every mode change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bank_sel <= 1'b0;
         r_mask     <= '0;
         r_gen      <= '0;
         r_swap_err <= 1'b0;
      end else begin
         r_swap_err <= w_swap_rej;
         if (!load_run) begin
            r_mask <= '0;
            r_gen  <= '0;
         end else if (w_swap_ok) begin
            r_bank_sel <= ~r_bank_sel;
            r_mask     <= '0;
            r_gen      <= r_gen + 1'b1;
         end else if (w_grid_wr) begin
            r_mask[grid_addr] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_valid <= 1'b0;
         r_prev     <= '0;
         r_cur      <= '0;
         r_next     <= '0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) begin
            if (w_rd_ok) begin
               r_prev <= r_bank[r_bank_sel][w_prev_idx];
               r_cur  <= r_bank[r_bank_sel][rd_addr];
               r_next <= r_bank[r_bank_sel][w_next_idx];
            end else begin
               r_prev <= '0;
               r_cur  <= '0;
               r_next <= '0;
            end
         end
      end
   end

   assign row_prev       = r_prev;
   assign row_cur        = r_cur;
   assign row_next       = r_next;
   assign rd_valid       = r_rd_valid;
   assign frame_complete = &r_mask;
   assign swap_err       = r_swap_err;
   assign gen_count      = r_gen;

endmodule

// File: tb/tb_grid_memory_banked.sv
// Bench for grid_memory_banked: directed and random stimulus against a queue-based scoreboard.
module tb_grid_memory_banked;
   localparam int W  = 8;
   localparam int R  = 6;
   localparam int AW = 3;
   localparam int G  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_run, load_we, grid_we, swap, rd_en;
   logic [AW-1:0] load_addr, grid_addr, rd_addr;
   logic [W-1:0]  initial_in, grid_in;
   logic [W-1:0]  row_prev, row_cur, row_next;
   logic          rd_valid, frame_complete, swap_err;
   logic [G-1:0]  gen_count;

   grid_memory_banked #(.WIDTH(W), .ROWS(R), .GEN_W(G)) dut (
      .clk(clk), .reset(reset), .load_run(load_run), .load_we(load_we),
      .load_addr(load_addr), .initial_in(initial_in), .grid_we(grid_we),
      .grid_addr(grid_addr), .grid_in(grid_in), .swap(swap), .rd_en(rd_en),
      .rd_addr(rd_addr), .row_prev(row_prev), .row_cur(row_cur),
      .row_next(row_next), .rd_valid(rd_valid), .frame_complete(frame_complete),
      .swap_err(swap_err), .gen_count(gen_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         vld;
      logic [W-1:0] p, c, n;
      logic         fc, serr;
      logic [G-1:0] gen;
   } exp_t;

   exp_t         q[$];
   logic [W-1:0] m_act[R], m_shd[R];
   logic         m_wr[R];
   int           m_gen;
   logic [W-1:0] m_p, m_c, m_n;
   logic         cur_lr;
   logic         mon_on = 1'b0;
   int           n_cmp = 0;
   int           n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < R; i++) begin
         m_act[i] = '0; m_shd[i] = '0; m_wr[i] = 1'b0;
      end
      m_gen = 0; m_p = '0; m_c = '0; m_n = '0;
   endtask

   // Apply one cycle of inputs; the reference model predicts what the DUT shows after the next edge.
   task automatic drive(input logic lr, input logic lwe, input logic [AW-1:0] la,
                        input logic [W-1:0] li, input logic gwe, input logic [AW-1:0] ga,
                        input logic [W-1:0] gi, input logic sw, input logic re,
                        input logic [AW-1:0] ra);
      exp_t         e;
      logic         serr, all_wr, fc;
      logic [W-1:0] tmp;
      @(negedge clk);
      load_run = lr; load_we = lwe; load_addr = la; initial_in = li;
      grid_we = gwe; grid_addr = ga; grid_in = gi; swap = sw;
      rd_en = re; rd_addr = ra;
      cur_lr = lr;
      if (re) begin
         if (int'(ra) < R) begin
            m_p = m_act[(int'(ra) + R - 1) % R];
            m_c = m_act[int'(ra)];
            m_n = m_act[(int'(ra) + 1) % R];
         end else begin
            m_p = '0; m_c = '0; m_n = '0;
         end
      end
      serr = 1'b0;
      if (!lr) begin
         if (lwe && int'(la) < R) m_act[int'(la)] = li;
         for (int i = 0; i < R; i++) m_wr[i] = 1'b0;
         m_gen = 0;
      end else begin
         all_wr = 1'b1;
         for (int i = 0; i < R; i++) all_wr &= m_wr[i];
         if (gwe && int'(ga) < R) begin
            m_shd[int'(ga)] = gi;
            m_wr[int'(ga)]  = 1'b1;
         end
         if (sw) begin
            if (all_wr && !gwe) begin
               for (int i = 0; i < R; i++) begin
                  tmp = m_act[i]; m_act[i] = m_shd[i]; m_shd[i] = tmp;
                  m_wr[i] = 1'b0;
               end
               m_gen = (m_gen + 1) % (1 << G);
            end else begin
               serr = 1'b1;
            end
         end
      end
      fc = 1'b1;
      for (int i = 0; i < R; i++) fc &= m_wr[i];
      e.vld = re; e.p = m_p; e.c = m_c; e.n = m_n;
      e.fc = fc; e.serr = serr; e.gen = G'(m_gen);
      q.push_back(e);
      mon_on = 1'b1;
   endtask

   task automatic idle(); drive(cur_lr, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic ld(input int a, input int d); drive(0, 1, AW'(a), W'(d), 0, 0, 0, 0, 0, 0); endtask
   task automatic gw(input int a, input int d, input logic s); drive(1, 0, 0, 0, 1, AW'(a), W'(d), s, 0, 0); endtask
   task automatic rd(input int a); drive(cur_lr, 0, 0, 0, 0, 0, 0, 0, 1, AW'(a)); endtask
   task automatic sw(); drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_on) begin
            if (q.size() == 0) begin
               chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("rd_valid", {31'd0, rd_valid}, {31'd0, e.vld});
               chk("rows", {8'd0, row_prev, row_cur, row_next}, {8'd0, e.p, e.c, e.n});
               chk("frame_complete", {31'd0, frame_complete}, {31'd0, e.fc});
               chk("swap_err", {31'd0, swap_err}, {31'd0, e.serr});
               chk("gen_count", {28'd0, gen_count}, {28'd0, e.gen});
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin : stim
      reset = 1'b0; cur_lr = 1'b0;
      load_run = 0; load_we = 0; load_addr = 0; initial_in = 0;
      grid_we = 0; grid_addr = 0; grid_in = 0; swap = 0; rd_en = 0; rd_addr = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_rows", {8'd0, row_prev, row_cur, row_next}, 32'd0);
      chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("reset_gen", {28'd0, gen_count}, 32'd0);
      chk("reset_swap_err", {31'd0, swap_err}, 32'd0);
      reset = 1'b1;

      rd(5);
      for (int i = 0; i < R; i++) ld(i, 1 << i);
      rd(0); rd(5); rd(6); rd(2);
      ld(7, 8'hFF); rd(7); rd(1);
      drive(0, 1, 3'd2, 8'hAA, 0, 0, 0, 0, 1, 3'd2);
      rd(2);
      drive(0, 0, 0, 0, 1, 3'd1, 8'h55, 1, 0, 0);
      rd(1);

      for (int i = 0; i < R - 1; i++) gw(i, 8'h10 + i, 0);
      gw(6, 8'hEE, 0);
      sw();
      gw(R - 1, 8'h15, 1);
      sw();
      rd(0); rd(R - 1); rd(3);

      for (int k = 0; k < 15; k++) begin
         for (int i = 0; i < R; i++) gw(i, $urandom_range(0, 255), 0);
         sw();
      end
      rd(0); rd(4);
      for (int i = 0; i < R; i++) gw(i, $urandom_range(0, 255), 0);
      idle();
      cur_lr = 1'b0;
      idle(); idle();

      for (int t = 0; t < 800; t++) begin
         logic lr;
         lr = cur_lr;
         if ($urandom_range(0, 59) == 0) lr = ~lr;
         drive(lr, ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 7)), W'($urandom),
               ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), W'($urandom),
               ($urandom_range(0, 9) < 2), ($urandom_range(0, 1) == 1),
               AW'($urandom_range(0, 7)));
      end

      cur_lr = 1'b1;
      for (int i = 0; i < 3; i++) gw(i, 8'h3C, 0);
      rd(3);
      @(posedge clk);
      #3;
      mon_on = 1'b0;
      reset = 1'b0;
      #1;
      chk("async_rows", {8'd0, row_prev, row_cur, row_next}, 32'd0);
      chk("async_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("async_fc", {31'd0, frame_complete}, 32'd0);
      chk("async_swap_err", {31'd0, swap_err}, 32'd0);
      chk("async_gen", {28'd0, gen_count}, 32'd0);
      @(negedge clk);
      load_run = 0; load_we = 0; grid_we = 0; swap = 0; rd_en = 0; cur_lr = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      model_reset();
      for (int a = 0; a < 8; a++) rd(a);
      idle();

      @(posedge clk);
      #2;
      mon_on = 1'b0;
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
